// File: rtl/ysyx_22040125_pkg.sv
// Shared widths, the pipeline entry layout and the halt FSM encoding for the
// ebreak/halt delay pipeline.
package ysyx_22040125_pkg;

  localparam int OP_W   = 15;
  localparam int INST_W = 32;
  localparam logic [OP_W-1:0] OP_NOP = 15'h0fff;

  typedef struct packed {
    logic              valid;
    logic              ebreak;
    logic [OP_W-1:0]   op;
    logic [INST_W-1:0] inst;
  } pipe_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } halt_state_e;

  function automatic pipe_entry_t bubble();
    pipe_entry_t e;
    e.valid  = 1'b0;
    e.ebreak = 1'b0;
    e.op     = OP_NOP;
    e.inst   = '0;
    return e;
  endfunction

endpackage

// File: rtl/ysyx_22040125_halt_stage.sv
// One pipeline entry register. clear beats hold, hold beats load.
module ysyx_22040125_halt_stage
  import ysyx_22040125_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        clear,
  input  pipe_entry_t d,
  output pipe_entry_t q
);

  always_ff @(posedge clk) begin
    if (rst || clear) q <= bubble();
    else if (!hold)   q <= d;
  end

endmodule

// File: rtl/ysyx_22040125_halt_pipe.sv
// Stallable DEPTH-stage delay line carrying ebreak/op/inst to commit, with a
// sticky halt raised by a retiring ebreak and a retired-instruction counter.
module ysyx_22040125_halt_pipe
  import ysyx_22040125_pkg::*;
#(
  parameter int              DEPTH  = 2,
  parameter int              OP_W   = ysyx_22040125_pkg::OP_W,
  parameter int              INST_W = ysyx_22040125_pkg::INST_W,
  parameter logic [OP_W-1:0] OP_NOP = ysyx_22040125_pkg::OP_NOP,
  parameter int              CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_ebreak,
  input  logic [OP_W-1:0]   in_op,
  input  logic [INST_W-1:0] in_inst,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic              out_ebreak,
  output logic [OP_W-1:0]   out_op,
  output logic [INST_W-1:0] out_inst,
  output logic              halted,
  output logic [INST_W-1:0] halt_inst,
  output logic [CNT_W-1:0]  retired_cnt
);

  // The entry struct is laid out with the package widths, so overrides must match.
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("ysyx_22040125_halt_pipe: DEPTH must be 1..8");
  end
  if (OP_W != ysyx_22040125_pkg::OP_W || INST_W != ysyx_22040125_pkg::INST_W ||
      OP_NOP != ysyx_22040125_pkg::OP_NOP) begin : g_bad_width
    $error("ysyx_22040125_halt_pipe: OP_W/INST_W/OP_NOP must match the package");
  end

  pipe_entry_t stg_q [DEPTH];
  pipe_entry_t entry_in;
  halt_state_e state, state_nxt;
  logic        retire, halt_commit, clear;

  assign out_valid  = stg_q[DEPTH-1].valid;
  assign out_ebreak = stg_q[DEPTH-1].ebreak;
  assign out_op     = stg_q[DEPTH-1].op;
  assign out_inst   = stg_q[DEPTH-1].inst;
  assign halted     = (state == ST_HALTED);

  assign retire      = out_valid && !stall;
  assign halt_commit = retire && out_ebreak;
  // While halted the stages only ever hold bubbles, so flush/stall are invisible.
  assign clear       = halt_commit || flush;

  always_comb begin
    entry_in = bubble();
    if (in_valid && !halted) begin
      entry_in.valid  = 1'b1;
      entry_in.ebreak = in_ebreak;
      entry_in.op     = in_op;
      entry_in.inst   = in_inst;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      ysyx_22040125_halt_stage u_stage (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall),
        .clear (clear),
        .d     (entry_in),
        .q     (stg_q[i])
      );
    end else begin : g_rest
      ysyx_22040125_halt_stage u_stage (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall),
        .clear (clear),
        .d     (stg_q[i-1]),
        .q     (stg_q[i])
      );
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_RUN && halt_commit) state_nxt = ST_HALTED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      halt_inst <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN && halt_commit) halt_inst <= out_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
  end

endmodule
